// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port has fixed priority, fetch is protected by a starvation limit.
// Optional bus-hang protection: define ARB_TIMEOUT_EN to build the BUSY timeout counter and err_o.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_ctrl,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_ctrl,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] CTRL_WORD  = 3'b010;

    state_t     state, state_nxt;
    logic [3:0] starve_cnt;
    logic       grant_d, grant_if, done, timeout_hit;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || starve_cnt < STARVE_MAX)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ready || timeout_hit) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_ctrl   <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_ctrl  <= d_ctrl;
                // Only data grants that bypass a waiting fetch count towards starvation.
                if (!if_req)
                    starve_cnt <= '0;
                else if (starve_cnt != 4'hF)
                    starve_cnt <= starve_cnt + 4'd1;
            end else if (grant_if) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                mem_ctrl   <= CTRL_WORD;
                starve_cnt <= '0;
            end else if (done) begin
                mem_req <= 1'b0;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            to_cnt <= '0;
        else if (grant_d || grant_if)
            to_cnt <= '0;
        else if (state != IDLE && !mem_ready && !timeout_hit)
            to_cnt <= to_cnt + 8'd1;
    end

    assign timeout_hit = (state != IDLE) && (to_cnt == TO_LAST);
    // A late mem_ready on the timeout cycle still counts as a normal completion.
    assign err_o       = timeout_hit && !mem_ready;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    assign if_ack   = (state == BUSY_IF) && done;
    assign d_ack    = (state == BUSY_D)  && done;
    assign if_rdata = (if_ack && mem_ready) ? mem_rdata : '0;
    assign d_rdata  = (d_ack  && mem_ready) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester/memory agents plus a transaction-level
// prediction of grants, acks and memory-port fields, followed by directed scenarios.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 8;
    localparam int NEVER = 1000;

    logic          clk;
    logic          reset;
    logic          if_req, d_req, d_we, mem_ready;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [2:0]    d_ctrl;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic          if_ack, d_ack, mem_req, mem_we, err_o;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_ctrl;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ctrl(d_ctrl),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {NONE, OWN_IF, OWN_D} owner_e;
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    ctrl;
    } txn_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level view: who owns memory, which requests wait, and what the port should show.
    txn_t   if_txn, d_txn, cur;
    bit     if_pend, d_pend, fields_known;
    owner_e owner;
    int     grants_past_fetch, busy_cycles, delay;
    bit     e_done, e_if_ack, e_d_ack;

    int p_if, p_d, delay_fix, rst_pct;
    bit rdata_fix;
    int errs;
    int ack_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        if (!if_pend && $urandom_range(99) < p_if) begin
            if_pend     = 1'b1;
            if_txn.addr = $urandom;
        end
        if (!d_pend && $urandom_range(99) < p_d) begin
            d_pend      = 1'b1;
            d_txn.we    = 1'($urandom_range(1));
            d_txn.addr  = $urandom;
            d_txn.wdata = $urandom;
            d_txn.ctrl  = 3'($urandom_range(7));
        end
        if_req    = if_pend;
        if_addr   = if_txn.addr;
        d_req     = d_pend;
        d_we      = d_txn.we;
        d_addr    = d_txn.addr;
        d_wdata   = d_txn.wdata;
        d_ctrl    = d_txn.ctrl;
        reset     = ($urandom_range(99) < rst_pct) ? 1'b0 : 1'b1;
        mem_ready = (owner != NONE) ? (busy_cycles == delay) : 1'($urandom_range(1));
        mem_rdata = rdata_fix ? 32'hDEAD_BEEF : $urandom;
    endtask

    task automatic compare();
        bit to_hit;
        logic [DW-1:0] exp_rd;
        to_hit = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to_hit = (owner != NONE) && (busy_cycles == TO - 1) && !mem_ready;
`endif
        e_done   = (owner != NONE) && (mem_ready || to_hit);
        e_if_ack = e_done && (owner == OWN_IF);
        e_d_ack  = e_done && (owner == OWN_D);

        check("mem_req", 64'(mem_req), 64'(owner != NONE));
        if (fields_known) begin
            check("mem_we", 64'(mem_we), 64'(cur.we));
            check("mem_addr", 64'(mem_addr), 64'(cur.addr));
            check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
            check("mem_ctrl", 64'(mem_ctrl), 64'(cur.ctrl));
        end
        check("if_ack", 64'(if_ack), 64'(e_if_ack));
        check("d_ack", 64'(d_ack), 64'(e_d_ack));
        check("err_o", 64'(err_o), 64'(to_hit));
        exp_rd = (e_if_ack && mem_ready) ? mem_rdata : '0;
        check("if_rdata", 64'(if_rdata), 64'(exp_rd));
        if (!(e_d_ack && mem_ready && cur.we)) begin
            exp_rd = (e_d_ack && mem_ready) ? mem_rdata : '0;
            check("d_rdata", 64'(d_rdata), 64'(exp_rd));
        end

        if (d_ack === 1'b1)  ack_log.push_back(0);
        if (if_ack === 1'b1) ack_log.push_back(1);
        if (err_o === 1'b1)  errs++;
    endtask

    task automatic pick_delay();
        if (delay_fix >= 0) begin
            delay = delay_fix;
        end else begin
            delay = $urandom_range(3);
            if ($urandom_range(19) == 0) delay = TO - 1;
`ifdef ARB_TIMEOUT_EN
            if ($urandom_range(19) == 0) delay = NEVER;
`endif
        end
    endtask

    // What the rising edge does to the transaction-level state.
    task automatic advance();
        if (e_if_ack) if_pend = 1'b0;
        if (e_d_ack)  d_pend  = 1'b0;
        if (reset == 1'b0) begin
            owner             = NONE;
            grants_past_fetch = 0;
            busy_cycles       = 0;
            cur               = '{we: 1'b0, addr: '0, wdata: '0, ctrl: '0};
            fields_known      = 1'b1;
            return;
        end
        if (owner != NONE) begin
            if (e_done) owner = NONE;
            else        busy_cycles++;
        end else if (d_pend && (!if_pend || grants_past_fetch < SL)) begin
            owner             = OWN_D;
            cur               = d_txn;
            grants_past_fetch = if_pend ? ((grants_past_fetch < 15) ? grants_past_fetch + 1 : 15) : 0;
            busy_cycles       = 0;
            fields_known      = 1'b1;
            pick_delay();
        end else if (if_pend) begin
            owner             = OWN_IF;
            cur               = '{we: 1'b0, addr: if_txn.addr, wdata: '0, ctrl: 3'b010};
            grants_past_fetch = 0;
            busy_cycles       = 0;
            fields_known      = 1'b1;
            pick_delay();
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            #1;
            compare();
            advance();
            @(negedge clk);
        end
    endtask

    function automatic int count_log(input int code);
        int c = 0;
        foreach (ack_log[k]) if (ack_log[k] == code) c++;
        return c;
    endfunction

    initial begin
        if_pend = 0; d_pend = 0; fields_known = 0; owner = NONE;
        grants_past_fetch = 0; busy_cycles = 0; delay = 0; errs = 0;
        if_txn = '{we: 1'b0, addr: '0, wdata: '0, ctrl: '0};
        d_txn  = if_txn;
        cur    = if_txn;
        rdata_fix = 0; delay_fix = 0;
        reset = 1'b0; if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b0;
        if_addr = '0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_ctrl = '0; mem_rdata = '0;
        @(negedge clk);
        fields_known = 1'b1;

        // Reset held with both requests pending; the first grant afterwards goes to data.
        p_if = 100; p_d = 100; rst_pct = 100;
        step(3);
        p_if = 0; p_d = 0; rst_pct = 0;
        ack_log.delete();
        step(5);
        check("first_grant_is_data", 64'(ack_log.size() > 0 ? ack_log[0] : 9), 64'(0));

        // Zero-wait fetch.
        if_pend = 1; if_txn.addr = 32'h100; rdata_fix = 1;
        ack_log.delete();
        step(3);
        check("zero_wait_fetch_acks", 64'(count_log(1)), 64'(1));
        rdata_fix = 0;

        // Data write with three wait states.
        d_pend = 1; d_txn = '{we: 1'b1, addr: 32'h2000, wdata: 32'h1234_5678, ctrl: 3'b010};
        delay_fix = 3;
        ack_log.delete();
        step(7);
        check("wait_state_d_acks", 64'(count_log(0)), 64'(1));
        check("wait_state_if_acks", 64'(count_log(1)), 64'(0));

        // Starvation: both requests held high continuously.
        rst_pct = 100; step(1); rst_pct = 0;
        p_if = 100; p_d = 100; delay_fix = 0;
        ack_log.delete();
        step(40);
        p_if = 0; p_d = 0;
        step(6);
        check("starve_log_len", 64'(ack_log.size() >= 10), 64'(1));
        for (int k = 0; k < 10; k++)
            if (k < ack_log.size())
                check("starve_seq", 64'(ack_log[k]), 64'((k % 5 == 4) ? 1 : 0));

        // Reset while a data read waits for memory.
        d_pend = 1; d_txn = '{we: 1'b0, addr: 32'h40, wdata: '0, ctrl: 3'b010};
        delay_fix = NEVER;
        ack_log.delete();
        step(2);
        rst_pct = 100; step(1); rst_pct = 0;
        check("reset_mid_no_ack", 64'(ack_log.size()), 64'(0));
        delay_fix = 0;
        step(4);

`ifdef ARB_TIMEOUT_EN
        d_pend = 1; d_txn = '{we: 1'b0, addr: 32'h80, wdata: '0, ctrl: 3'b010};
        delay_fix = NEVER; errs = 0;
        step(12);
        check("timeout_err_count", 64'(errs), 64'(1));
        d_pend = 1; delay_fix = TO - 1; errs = 0;
        step(12);
        check("late_ready_no_err", 64'(errs), 64'(0));
`endif

        // Randomized traffic with occasional resets.
        p_if = 40; p_d = 50; delay_fix = -1; rst_pct = 1;
        step(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
